lsr_serial_engine: RTL and testbench

//  Multi-cycle, bit-serial counterpart of the combinational logic/shift/rotate unit.

---
 rtl/lsr_serial_engine.sv | 198 +++++++++++++++++++
 tb/tb_lsr_serial_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsr_serial_engine.sv
// lsr_serial_engine
//   Bit-serial logic/shift/rotate engine. Takes one command (op, A, B) on a
//   valid/ready request port. Shifts and rotates advance one bit position per
//   clock, B clocks in total. Logic ops finish on the accept edge. The result
//   and its flags are held on a valid/ready response port.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   command handshake; in_ready is high only in IDLE
//   in_op                 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR,
//                         101 AND, 110 OR, 111 XOR
//   in_a                  data to shift, or logic operand
//   in_b                  unsigned shift/rotate count, or logic operand
//   out_valid / out_ready result handshake; out_valid is high only in DONE
//   out_data              result
//   out_sbit              last bit shifted or rotated out (0 for logic ops
//                         and for a zero count)
//   out_zero              out_data == 0
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a command; accepts on in_valid
// SHIFT | one 1-bit step per clock until the count reaches zero
// DONE  | result presented; waits for out_ready, accepts nothing

module lsr_serial_engine #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sbit,
  output logic             out_zero
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_sbit;

  logic             w_accept;
  logic             w_is_logic;
  logic             w_cnt_zero_in;
  logic             w_last_step;
  logic [WIDTH-1:0] w_logic_res;
  logic [WIDTH-1:0] w_acc_step;
  logic             w_sbit_step;

  assign w_accept      = (r_state == S_IDLE) && in_valid;
  assign w_is_logic    = (in_op == OP_AND) || (in_op == OP_OR) || (in_op == OP_XOR);
  assign w_cnt_zero_in = (in_b == '0);
  assign w_last_step   = (r_cnt == CNT_ONE);

  always_comb begin
    w_logic_res = '0;
    case (in_op)
      OP_AND:  w_logic_res = in_a & in_b;
      OP_OR:   w_logic_res = in_a | in_b;
      OP_XOR:  w_logic_res = in_a ^ in_b;
      default: w_logic_res = '0;
    endcase
  end

  // One 1-bit step of the captured operation applied to the accumulator.
  always_comb begin
    w_acc_step  = r_acc;
    w_sbit_step = 1'b0;
    case (r_op)
      OP_SLL: begin
        w_acc_step  = {r_acc[WIDTH-2:0], 1'b0};
        w_sbit_step = r_acc[WIDTH-1];
      end
      OP_SRL: begin
        w_acc_step  = {1'b0, r_acc[WIDTH-1:1]};
        w_sbit_step = r_acc[0];
      end
      OP_SRA: begin
        w_acc_step  = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
        w_sbit_step = r_acc[0];
      end
      OP_ROL: begin
        w_acc_step  = {r_acc[WIDTH-2:0], r_acc[WIDTH-1]};
        w_sbit_step = r_acc[WIDTH-1];
      end
      OP_ROR: begin
        w_acc_step  = {r_acc[0], r_acc[WIDTH-1:1]};
        w_sbit_step = r_acc[0];
      end
      default: begin
        w_acc_step  = r_acc;
        w_sbit_step = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_is_logic || w_cnt_zero_in) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (w_last_step) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The accumulator is the working register; r_data/r_sbit are loaded only
  // when a result is complete, so the presented result never shows a partial
  // shift and survives the response handshake unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_SLL;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_data <= '0;
      r_sbit <= 1'b0;
    end else if (w_accept) begin
      r_op  <= in_op;
      r_cnt <= in_b;
      if (w_is_logic) begin
        r_acc  <= w_logic_res;
        r_data <= w_logic_res;
        r_sbit <= 1'b0;
      end else begin
        r_acc <= in_a;
        if (w_cnt_zero_in) begin
          r_data <= in_a;
          r_sbit <= 1'b0;
        end
      end
    end else if (r_state == S_SHIFT) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt - CNT_ONE;
      if (w_last_step) begin
        r_data <= w_acc_step;
        r_sbit <= w_sbit_step;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_data;
  assign out_sbit  = r_sbit;
  assign out_zero  = (r_data == '0);

endmodule

// File: tb/tb_lsr_serial_engine.sv
// tb_lsr_serial_engine
//   Self-checking bench for lsr_serial_engine (WIDTH=4): a table of directed
//   vectors, hand-written handshake/backpressure/reset sequences, and random
//   commands compared against an arithmetic reference model.

module tb_lsr_serial_engine;

  localparam int W = 4;

  localparam logic [2:0] SLL = 3'b000;
  localparam logic [2:0] SRL = 3'b001;
  localparam logic [2:0] SRA = 3'b010;
  localparam logic [2:0] ROL = 3'b011;
  localparam logic [2:0] ROR = 3'b100;
  localparam logic [2:0] AND = 3'b101;
  localparam logic [2:0] OR  = 3'b110;
  localparam logic [2:0] XOR = 3'b111;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_sbit;
  logic         out_zero;

  int n_cmp = 0;
  int n_err = 0;

  lsr_serial_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sbit  (out_sbit),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
    logic         sbit;
    int           off;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: whole-operation arithmetic on wide vectors. The last bit out
  // of a shift lands just past the kept field; for rotates it is the bit that
  // wrapped around last.
  function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic [63:0]        y;
    logic signed [63:0] ys;
    logic [W-1:0]       d;
    logic               s;
    int                 r;
    d = '0;
    s = 1'b0;
    r = int'(b) % W;
    case (op)
      SLL: begin
        y = {{(64-W){1'b0}}, a} << b;
        d = y[W-1:0];
        s = y[W];
      end
      SRL: begin
        y = {a, {(64-W){1'b0}}} >> b;
        d = y[63 -: W];
        s = y[63-W];
      end
      SRA: begin
        ys = $signed({a, {(64-W){1'b0}}}) >>> b;
        d = ys[63 -: W];
        s = ys[63-W];
      end
      ROL: begin
        d = (a << r) | (a >> (W - r));
        s = (b == '0) ? 1'b0 : d[0];
      end
      ROR: begin
        d = (a >> r) | (a << (W - r));
        s = (b == '0) ? 1'b0 : d[W-1];
      end
      AND: d = a & b;
      OR:  d = a | b;
      default: d = a ^ b;
    endcase
    return {s, d};
  endfunction

  function automatic int model_off(input logic [2:0] op, input logic [W-1:0] b);
    if (op >= AND || b == '0) return 0;
    return int'(b);
  endfunction

  // Called at posedge+1; returns at posedge+1 with the result in DONE (or
  // after the cycle budget runs out).
  task automatic issue_wait(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int exp_off);
    int off;
    chk({nm, "_in_ready_before"}, in_ready, 1'b1);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 3'($urandom);
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    off = 0;
    while (!out_valid && off < 40) begin
      @(posedge clk);
      #1;
      off++;
    end
    chk({nm, "_offset"}, off, exp_off);
  endtask

  task automatic release_chk(input string nm, input logic [W-1:0] exp_data);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_valid_after_ack"}, out_valid, 1'b0);
    chk({nm, "_ready_after_ack"}, in_ready, 1'b1);
    chk({nm, "_data_retained"}, out_data, exp_data);
  endtask

  task automatic run_cmd(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_data,
                         input logic exp_sbit, input int exp_off);
    issue_wait(nm, op, a, b, exp_off);
    chk({nm, "_data"}, out_data, exp_data);
    chk({nm, "_sbit"}, out_sbit, exp_sbit);
    chk({nm, "_zero"}, out_zero, (exp_data == '0));
    release_chk(nm, exp_data);
  endtask

  initial begin
    logic [W:0]   m;
    logic [2:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         exp_rdy;

    tbl[0] = '{SLL, 4'b0011, 4'd2,    4'b1100, 1'b0, 2};
    tbl[1] = '{SRA, 4'b1000, 4'd3,    4'b1111, 1'b0, 3};
    tbl[2] = '{SRL, 4'b1000, 4'd7,    4'b0000, 1'b0, 7};
    tbl[3] = '{ROR, 4'b0001, 4'd5,    4'b1000, 1'b1, 5};
    tbl[4] = '{ROL, 4'b1001, 4'd0,    4'b1001, 1'b0, 0};
    tbl[5] = '{XOR, 4'b1010, 4'b0110, 4'b1100, 1'b0, 0};
    tbl[6] = '{AND, 4'b1010, 4'b0101, 4'b0000, 1'b0, 0};
    tbl[7] = '{OR,  4'b1010, 4'b0100, 4'b1110, 1'b0, 0};
    tbl[8] = '{SLL, 4'b1011, 4'd4,    4'b0000, 1'b1, 4};
    tbl[9] = '{SRA, 4'b0111, 4'd15,   4'b0000, 1'b0, 15};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_sbit", out_sbit, 1'b0);
    chk("rst_out_zero", out_zero, 1'b1);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
              tbl[i].data, tbl[i].sbit, tbl[i].off);
    end

    // Continuous requests with out_ready held high: accepts every other edge.
    out_ready = 1'b1;
    in_op     = XOR;
    in_a      = 4'b1010;
    in_b      = 4'b0110;
    in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = (k % 2 == 0);
      chk($sformatf("issue_gap_ready%0d", k), in_ready, exp_rdy);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("issue_gap_data", out_data, 4'b1100);

    // Backpressure: result frozen while new commands are offered.
    issue_wait("bp", ROR, 4'b0001, 4'd5, 5);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      in_op    = SLL;
      in_a     = W'($urandom);
      in_b     = 4'd1;
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid%0d", k), out_valid, 1'b1);
      chk($sformatf("bp_ready%0d", k), in_ready, 1'b0);
      chk($sformatf("bp_data%0d", k), out_data, 4'b1000);
      chk($sformatf("bp_sbit%0d", k), out_sbit, 1'b1);
    end
    in_valid = 1'b0;
    release_chk("bp", 4'b1000);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_no_extra_valid", out_valid, 1'b0);
    end

    // Reset in the middle of a long shift.
    in_op    = SLL;
    in_a     = 4'b0101;
    in_b     = 4'd15;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("midop_busy", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_valid", out_valid, 1'b0);
    chk("midop_rst_data", out_data, '0);
    chk("midop_rst_zero", out_zero, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midop_ready_after", in_ready, 1'b1);
    chk("midop_valid_after", out_valid, 1'b0);
    run_cmd("after_rst", SLL, 4'b0011, 4'd2, 4'b1100, 1'b0, 2);

    // Random commands against the reference model.
    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = W'($urandom);
      m   = model(rop, ra, rb);
      run_cmd($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb, m[W-1:0], m[W],
              model_off(rop, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
